bp_fe_ram64x15_ctl: RTL and testbench

Request-side controller for the 64x15 single-port front-end RAM macro. It turns a valid/ready request stream (reads and masked writes) into the macro's `ce`/`we`/`addr`/`wd`/`w_mask` pins and captures `rd_out` into a 2-entry response queue with valid/ready backpressure. It can optionally sweep the whole array to zero after reset. The block sits between the front-end predictor logic and the RAM macro and owns every macro access.

---
 rtl/bp_fe_ram64x15_ctl.sv | 121 ++++++++++++
 tb/tb_bp_fe_ram64x15_ctl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_ram64x15_ctl.sv
// bp_fe_ram64x15_ctl: request/response controller for the 64x15 front-end RAM.
// Define BP_FE_RAM_INIT_CLEAR_EN to compile in the post-reset zeroing sweep.
module bp_fe_ram64x15_ctl #(
    parameter int BITS       = 15,
    parameter int WORD_DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  req_v_in,
    output logic                  req_ready_out,
    input  logic                  req_we_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [BITS-1:0]       req_data_in,
    input  logic [BITS-1:0]       req_mask_in,
    output logic                  resp_v_out,
    input  logic                  resp_ready_in,
    output logic [BITS-1:0]       resp_data_out,
    output logic                  init_done_out,
    output logic                  ram_ce_out,
    output logic                  ram_we_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic [BITS-1:0]       ram_wd_out,
    output logic [BITS-1:0]       ram_w_mask_out,
    input  logic [BITS-1:0]       ram_rd_in
);

    if (WORD_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("WORD_DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [1:0]      count;
    logic [1:0]      occ;
    logic            inflight;
    logic            head;
    logic            tail;
    logic            init_done;
    logic            accept;
    logic            push;
    logic            pop;
    logic [BITS-1:0] q [2];

    // Credits cover both queued entries and the read still in the macro
    assign occ           = count + {1'b0, inflight};
    assign resp_v_out    = (count != 2'd0);
    assign pop           = resp_v_out & resp_ready_in;
    assign push          = inflight;
    assign tail          = head ^ count[0];
    assign req_ready_out = init_done & ~reset_in & ((occ < 2'd2) | pop);
    assign accept        = req_v_in & req_ready_out;
    assign resp_data_out = q[head];
    assign init_done_out = init_done;

`ifdef BP_FE_RAM_INIT_CLEAR_EN
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  sweeping;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end
    end

    assign sweeping       = (state == ST_INIT) & ~reset_in;
    assign ram_ce_out     = sweeping | accept;
    assign ram_we_out     = sweeping | (accept & req_we_in);
    assign ram_addr_out   = sweeping ? sweep_cnt : req_addr_in;
    assign ram_wd_out     = sweeping ? '0 : req_data_in;
    assign ram_w_mask_out = sweeping ? '1 : req_mask_in;
`else
    // Reset leaves the array alone, so the block is usable as soon as reset drops
    always_ff @(posedge clk) begin
        init_done <= 1'b1;
    end

    assign ram_ce_out     = accept;
    assign ram_we_out     = accept & req_we_in;
    assign ram_addr_out   = req_addr_in;
    assign ram_wd_out     = req_data_in;
    assign ram_w_mask_out = req_mask_in;
`endif

    always_ff @(posedge clk) begin
        if (reset_in) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            head     <= 1'b0;
        end else begin
            inflight <= accept & ~req_we_in;
            if (pop) begin
                head <= ~head;
            end
            unique case (1'b1)
                push & ~pop: count <= count + 2'd1;
                pop & ~push: count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q[tail] <= ram_rd_in;
        end
    end

endmodule

// File: tb/tb_bp_fe_ram64x15_ctl.sv
// Bench for bp_fe_ram64x15_ctl: directed scenarios plus random traffic
// scored against an array/queue reference model.
module tb_bp_fe_ram64x15_ctl;

    logic        clk;
    logic        reset_in;
    logic        req_v_in;
    logic        req_ready_out;
    logic        req_we_in;
    logic [5:0]  req_addr_in;
    logic [14:0] req_data_in;
    logic [14:0] req_mask_in;
    logic        resp_v_out;
    logic        resp_ready_in;
    logic [14:0] resp_data_out;
    logic        init_done_out;
    logic        ram_ce_out;
    logic        ram_we_out;
    logic [5:0]  ram_addr_out;
    logic [14:0] ram_wd_out;
    logic [14:0] ram_w_mask_out;
    logic [14:0] ram_rd_in;

    bp_fe_ram64x15_ctl dut (
        .clk            (clk),
        .reset_in       (reset_in),
        .req_v_in       (req_v_in),
        .req_ready_out  (req_ready_out),
        .req_we_in      (req_we_in),
        .req_addr_in    (req_addr_in),
        .req_data_in    (req_data_in),
        .req_mask_in    (req_mask_in),
        .resp_v_out     (resp_v_out),
        .resp_ready_in  (resp_ready_in),
        .resp_data_out  (resp_data_out),
        .init_done_out  (init_done_out),
        .ram_ce_out     (ram_ce_out),
        .ram_we_out     (ram_we_out),
        .ram_addr_out   (ram_addr_out),
        .ram_wd_out     (ram_wd_out),
        .ram_w_mask_out (ram_w_mask_out),
        .ram_rd_in      (ram_rd_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port macro
    logic [14:0] ram [64];
    always @(posedge clk) begin
        if (ram_ce_out) begin
            if (ram_we_out)
                ram[ram_addr_out] <= (ram[ram_addr_out] & ~ram_w_mask_out)
                                   | (ram_wd_out & ram_w_mask_out);
            else
                ram_rd_in <= ram[ram_addr_out];
        end
    end

    typedef struct {
        logic [14:0] d;
        int          vis;
    } rsp_t;

    rsp_t        q[$];
    logic [14:0] mem_m [64];
    logic        init_m;
    int          cyc;
    int          n_chk;
    int          n_err;
    int          n_pop;
    int          n_dut_acc;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic we, input logic [5:0] a,
                        input logic [14:0] d, input logic [14:0] m,
                        input logic rr, output logic acc);
        logic hv, pop, er;
        rsp_t e;
        req_v_in      = v;
        req_we_in     = we;
        req_addr_in   = a;
        req_data_in   = d;
        req_mask_in   = m;
        resp_ready_in = rr;
        @(negedge clk);
        hv  = (q.size() > 0) && (q[0].vis <= cyc);
        pop = hv && rr;
        er  = init_m && ((q.size() < 2) || pop);
        acc = v && er;
        check_eq("ready", req_ready_out, er);
        check_eq("resp_v", resp_v_out, hv);
        if (hv) check_eq("resp_data", resp_data_out, q[0].d);
        check_eq("ce", ram_ce_out, acc);
        check_eq("we", ram_we_out, acc && we);
        check_eq("init_done", init_done_out, init_m);
        if (acc) begin
            check_eq("addr", ram_addr_out, a);
            if (we) begin
                check_eq("wd", ram_wd_out, d);
                check_eq("mask", ram_w_mask_out, m);
            end
        end
        if (resp_v_out && rr) n_pop++;
        if (v && req_ready_out) n_dut_acc++;
        @(posedge clk);
        cyc++;
        if (pop) void'(q.pop_front());
        if (acc) begin
            if (we) begin
                mem_m[a] = (mem_m[a] & ~m) | (d & m);
            end else begin
                e.d   = mem_m[a];
                e.vis = cyc + 1;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_in      = 1'b1;
        req_v_in      = 1'b0;
        resp_ready_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_ready", req_ready_out, 0);
            check_eq("rst_ce", ram_ce_out, 0);
            check_eq("rst_we", ram_we_out, 0);
            if (i > 0) check_eq("rst_resp_v", resp_v_out, 0);
            @(posedge clk);
            cyc++;
            #1;
        end
        q.delete();
        reset_in = 1'b0;
`ifdef BP_FE_RAM_INIT_CLEAR_EN
        init_m = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check_eq("sweep_ce", ram_ce_out, 1);
            check_eq("sweep_we", ram_we_out, 1);
            check_eq("sweep_addr", ram_addr_out, i);
            check_eq("sweep_wd", ram_wd_out, 0);
            check_eq("sweep_mask", ram_w_mask_out, 32'h7FFF);
            check_eq("sweep_ready", req_ready_out, 0);
            check_eq("sweep_done", init_done_out, 0);
            @(posedge clk);
            cyc++;
            #1;
        end
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
`endif
        init_m = 1'b1;
    endtask

    initial begin
        logic acc;
        int   got, p0, base;
        n_chk = 0; n_err = 0; n_pop = 0; n_dut_acc = 0; cyc = 0;
        init_m = 1'b0;
        reset_in = 1'b1; req_v_in = 1'b0; req_we_in = 1'b0;
        req_addr_in = '0; req_data_in = '0; req_mask_in = '0;
        resp_ready_in = 1'b1;
        for (int i = 0; i < 64; i++) mem_m[i] = 'x;
        #1;
        do_reset();

`ifdef BP_FE_RAM_INIT_CLEAR_EN
        step(1, 0, 17, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        check_eq("init_rd17", resp_data_out, 0);
        step(0, 0, 0, 0, 0, 1, acc);
`endif

        // Masked write then read
        step(1, 1, 5, 15'h7FFF, 15'h7FFF, 1, acc);
        step(1, 1, 5, 15'h0000, 15'h00FF, 1, acc);
        step(1, 0, 5, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        check_eq("mw_v", resp_v_out, 1);
        check_eq("mw_data", resp_data_out, 32'h7F00);
        step(0, 0, 0, 0, 0, 1, acc);

        // Write then read on consecutive accepts
        step(1, 1, 63, 15'h1234, 15'h7FFF, 1, acc);
        step(1, 0, 63, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        check_eq("wr63_data", resp_data_out, 32'h1234);
        step(0, 0, 0, 0, 0, 1, acc);

        // Streaming
        for (int i = 0; i < 64; i++)
            step(1, 1, 6'(i), 15'(i), 15'h7FFF, 1, acc);
        p0 = n_pop; base = n_dut_acc;
        for (int i = 0; i < 64; i++)
            step(1, 0, 6'(i), 0, 0, 1, acc);
        check_eq("stream_acc", n_dut_acc - base, 64);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 1, acc);
        check_eq("stream_resp", n_pop - p0, 64);

        // Backpressure
        base = n_dut_acc; got = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 6'(1 + got), 0, 0, 0, acc);
            if (acc) got++;
        end
        check_eq("bp_acc", n_dut_acc - base, 2);
        check_eq("bp_ready", req_ready_out, 0);
        check_eq("bp_head", resp_data_out, 1);
        p0 = n_pop;
        for (int i = 0; i < 12; i++) begin
            step(got < 4, 0, 6'(1 + got), 0, 0, 1, acc);
            if (acc) got++;
        end
        check_eq("bp_resp", n_pop - p0, 4);

        // Reset with a queued entry and a read in flight
        step(1, 0, 10, 0, 0, 0, acc);
        step(1, 0, 11, 0, 0, 0, acc);
        do_reset();
        p0 = n_pop;
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 1, acc);
        check_eq("rst_stale", n_pop - p0, 0);

`ifdef BP_FE_RAM_INIT_CLEAR_EN
        for (int i = 0; i < 64; i++)
            step(1, 1, 6'(i), 15'($urandom), 15'h7FFF, 1, acc);
`endif

        // Random traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                 6'($urandom), 15'($urandom), 15'($urandom),
                 $urandom_range(0, 9) < 7, acc);
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 0, 0, 1, acc);
        check_eq("drain_v", resp_v_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
